// File: rtl/store_pkg.sv
// store_pkg: shared types for the store path (size encoding, buffered
// entry layout, drain FSM states) plus a small alignment helper.
package store_pkg;

  // Store data path is fixed at one 32-bit word with four byte lanes.
  localparam int ST_DW     = 32;
  localparam int ST_STRB_W = ST_DW / 8;

  // Address width carried by a buffered entry; store_ctrl's AW must match it.
  localparam int ST_ENTRY_AW = 32;

  // Store size encoding, shared with the control unit's decode of funct3.
  typedef enum logic [1:0] {
    SZ_W   = 2'b00,
    SZ_H   = 2'b01,
    SZ_B   = 2'b10,
    SZ_ILL = 2'b11
  } st_size_e;

  // Drain sequencer: either waiting for work or presenting a write.
  typedef enum logic {
    DR_IDLE = 1'b0,
    DR_REQ  = 1'b1
  } drain_state_e;

  // One buffered store, already word-aligned and lane-formatted.
  typedef struct packed {
    logic [ST_ENTRY_AW-1:0] addr;
    logic [ST_DW-1:0]       wdata;
    logic [ST_STRB_W-1:0]   strb;
  } st_entry_t;

  // True when a store of this size may start at byte offset off.
  function automatic logic size_aligned(input st_size_e size, input logic [1:0] off);
    case (size)
      SZ_W:    return off == 2'b00;
      SZ_H:    return off[0] == 1'b0;
      SZ_B:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_ctrl_lane_fmt.sv
// st_lane_fmt: purely combinational front end of the store path. Checks
// that the request is legal and naturally aligned, then replicates the
// low-justified rs2 data across the byte lanes and builds the strobes.
module st_lane_fmt
  import store_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0]    addr,
  input  logic [ST_DW-1:0] data,
  input  st_size_e         size,
  output logic             ok,
  output st_entry_t        entry
);

  logic [1:0] off;

  assign off = addr[1:0];

  // Alignment verdict plus lane replication; the strobe is shifted to the byte offset.
  always_comb begin
    ok         = size_aligned(size, off);
    entry      = '0;
    entry.addr = addr & ~AW'(3);
    case (size)
      SZ_W: begin
        entry.wdata = data;
        entry.strb  = 4'b1111;
      end
      SZ_H: begin
        entry.wdata = {2{data[15:0]}};
        entry.strb  = 4'b0011 << off;
      end
      SZ_B: begin
        entry.wdata = {4{data[7:0]}};
        entry.strb  = 4'b0001 << off;
      end
      default: begin
        entry.wdata = '0;
        entry.strb  = '0;
      end
    endcase
  end

endmodule

// File: rtl/store_ctrl.sv
// store_ctrl: store buffer between execute and data memory. Accepted stores
// are formatted, queued in order, and drained one at a time over a
// valid/ready write port. The entry being written stays in the buffer until
// memory takes it, so the load-hazard compare also covers the in-flight write.
module store_ctrl
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [1:0]    st_size,
  output logic          st_stall,
  output logic          st_misalign,

  input  logic [AW-1:0] ld_addr,
  input  logic          ld_valid,
  output logic          ld_hazard,

  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_ready,

  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  st_entry_t     fifo [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nx;
  logic [CW-1:0] count;

  logic          fmt_ok;
  st_entry_t     fmt_entry;

  logic          accept;
  logic          push;
  logic          pop;

  drain_state_e  state_q;
  drain_state_e  state_d;
  logic          req_d;
  logic          load_head;
  st_entry_t     head_d;

  st_lane_fmt #(
    .AW (AW)
  ) u_fmt (
    .addr  (st_addr),
    .data  (st_data),
    .size  (st_size_e'(st_size)),
    .ok    (fmt_ok),
    .entry (fmt_entry)
  );

  // A write completing this cycle frees its slot, so a full buffer can still accept.
  assign pop       = mem_req && mem_ready;
  assign st_stall  = (count == CW'(DEPTH)) && !pop;
  assign accept    = st_valid && !st_stall;
  assign push      = accept && fmt_ok;
  assign rd_ptr_nx = rd_ptr + 1'b1;
  assign empty     = (count == '0) && !mem_req;

  // Buffer storage: the formatted request lands at the tail when enqueued.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= fmt_entry;
    end
  end

  // Tail/head pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nx;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dropped requests are reported one cycle after the attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_misalign <= 1'b0;
    end else begin
      st_misalign <= accept && !fmt_ok;
    end
  end

  // Drain next-state: pick the entry to present next and whether to keep requesting.
  always_comb begin
    state_d   = state_q;
    req_d     = mem_req;
    load_head = 1'b0;
    head_d    = fifo[rd_ptr];
    case (state_q)
      DR_IDLE: begin
        if (count != '0) begin
          load_head = 1'b1;
          req_d     = 1'b1;
          state_d   = DR_REQ;
        end
      end
      DR_REQ: begin
        if (mem_ready) begin
          if (count > CW'(1)) begin
            load_head = 1'b1;
            head_d    = fifo[rd_ptr_nx];
          end else if (push) begin
            // Only the store arriving right now remains; it is not in the array yet.
            load_head = 1'b1;
            head_d    = fmt_entry;
          end else begin
            req_d   = 1'b0;
            state_d = DR_IDLE;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = DR_IDLE;
      end
    endcase
  end

  // Drain registers: the write port holds its values steady until memory accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DR_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state_q <= state_d;
      mem_req <= req_d;
      if (load_head) begin
        mem_addr  <= head_d.addr;
        mem_wdata <= head_d.wdata;
        mem_wstrb <= head_d.strb;
      end
    end
  end

  // Conservative word-granular hazard: any occupied slot on the load's word blocks it.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_valid &&
          (CW'(PW'(PW'(i) - rd_ptr)) < count) &&
          (fifo[i].addr == (ld_addr & ~AW'(3)))) begin
        ld_hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_ctrl.sv
// tb_store_ctrl: directed scenarios with literal expectations, followed by a
// randomized run, all continuously compared against a queue-based model.
module tb_store_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_stall;
  logic        st_misalign;
  logic [31:0] ld_addr;
  logic        ld_valid;
  logic        ld_hazard;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        empty;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } ent_t;

  // Model state: pending stores in order (head is the one being written).
  ent_t mq[$];
  bit   m_req;
  bit   m_mis;

  always #5 clk = ~clk;

  store_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .st_stall    (st_stall),
    .st_misalign (st_misalign),
    .ld_addr     (ld_addr),
    .ld_valid    (ld_valid),
    .ld_hazard   (ld_hazard),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .empty       (empty)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] sz, input bit rdy);
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_size   = sz;
    mem_ready = rdy;
  endtask

  task automatic drainAll();
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    ld_valid  = 1'b0;
    for (int i = 0; i < 40 && empty !== 1'b1; i++) step();
    checkOutput("drain_empty", empty, 1);
    step();
  endtask

  // Reference formatting: byte count from size, lanes filled by repeating the low bytes.
  function automatic void fmtRef(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] sz, output bit ok, output ent_t e);
    int n;
    int off;
    n       = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 0;
    off     = int'(a % 4);
    e.addr  = a - (a % 4);
    e.wdata = '0;
    e.strb  = '0;
    ok      = (n != 0) && ((off % ((n == 0) ? 1 : n)) == 0);
    if (n != 0) begin
      for (int b = 0; b < 4; b++) begin
        e.wdata[8*b +: 8] = d[8*(b % n) +: 8];
        if (b >= off && b < off + n) e.strb[b] = 1'b1;
      end
    end
  endfunction

  // Model update: one step of the buffer per clock, using pre-edge inputs.
  always @(posedge clk or negedge rst_n) begin : model
    bit   pop;
    bit   stall;
    bit   acc;
    bit   ok;
    int   pre;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_req = 1'b0;
      m_mis = 1'b0;
    end else begin
      pre   = mq.size();
      pop   = m_req && mem_ready;
      stall = (pre == DEPTH) && !pop;
      acc   = st_valid && !stall;
      fmtRef(st_addr, st_data, st_size, ok, e);
      m_mis = acc && !ok;
      if (pop) void'(mq.pop_front());
      if (acc && ok) mq.push_back(e);
      if (m_req) m_req = !pop || (mq.size() > 0);
      else       m_req = (pre > 0);
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin : compare
    bit hz;
    if (!rst_n) begin
      checkOutput("rst_mem_req", mem_req, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_mem_wstrb", mem_wstrb, 0);
      checkOutput("rst_misalign", st_misalign, 0);
      checkOutput("rst_empty", empty, 1);
      checkOutput("rst_stall", st_stall, 0);
    end else begin
      checkOutput("mem_req", mem_req, m_req);
      if (m_req && mq.size() > 0) begin
        checkOutput("mem_addr", mem_addr, mq[0].addr);
        checkOutput("mem_wdata", mem_wdata, mq[0].wdata);
        checkOutput("mem_wstrb", mem_wstrb, mq[0].strb);
      end
      checkOutput("st_misalign", st_misalign, m_mis);
      checkOutput("empty", empty, (mq.size() == 0) && !m_req);
      checkOutput("st_stall", st_stall, (mq.size() == DEPTH) && !(m_req && mem_ready));
      hz = 1'b0;
      if (ld_valid) begin
        foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) hz = 1'b1;
      end
      checkOutput("ld_hazard", ld_hazard, hz);
    end
  end

  initial begin
    int rdyPct;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    ld_valid = 1'b0;
    ld_addr  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_mem_req", mem_req, 0);
    #1 rst_n = 1'b1;
    step();

    // Byte store at offset 3 drains one cycle after enqueue.
    $display("[TB] sb single write");
    applyStimulus(1'b1, 32'h1003, 32'h0000_00AB, 2'b10, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    step();
    checkOutput("sb_req", mem_req, 1);
    checkOutput("sb_addr", mem_addr, 32'h1000);
    checkOutput("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    checkOutput("sb_wstrb", mem_wstrb, 4'b1000);
    step();
    checkOutput("sb_done_req", mem_req, 0);
    checkOutput("sb_done_empty", empty, 1);
    drainAll();

    // Halfword held stable while memory withholds ready.
    $display("[TB] sh with backpressure");
    applyStimulus(1'b1, 32'h2002, 32'h1234_BEEF, 2'b01, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("sh_req", mem_req, 1);
      checkOutput("sh_addr", mem_addr, 32'h2000);
      checkOutput("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      checkOutput("sh_wstrb", mem_wstrb, 4'b1100);
    end
    mem_ready = 1'b1;
    step();
    checkOutput("sh_popped_req", mem_req, 0);
    checkOutput("sh_popped_empty", empty, 1);
    drainAll();

    // Fill the buffer, stall the fifth, then drain in order.
    $display("[TB] full buffer");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 32'h1000 + 32'(i), 2'b00, 1'b0);
      step();
    end
    applyStimulus(1'b1, 32'h10, 32'h1004, 2'b00, 1'b0);
    #1 checkOutput("full_stall", st_stall, 1);
    step();
    applyStimulus(1'b1, 32'h10, 32'h1004, 2'b00, 1'b1);
    #1 checkOutput("full_pop_unstall", st_stall, 0);
    step();
    checkOutput("order_1", mem_addr, 32'h4);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    step();
    checkOutput("order_2", mem_addr, 32'h8);
    step();
    checkOutput("order_3", mem_addr, 32'hC);
    step();
    checkOutput("order_4", mem_addr, 32'h10);
    checkOutput("order_4_data", mem_wdata, 32'h1004);
    step();
    checkOutput("order_end_req", mem_req, 0);
    drainAll();

    // Misaligned and illegal requests are dropped with a pulse each.
    $display("[TB] misalign");
    applyStimulus(1'b1, 32'h3001, 32'h1111_1111, 2'b00, 1'b1);
    step();
    checkOutput("mis_sw", st_misalign, 1);
    applyStimulus(1'b1, 32'h3003, 32'h2222_2222, 2'b01, 1'b1);
    step();
    checkOutput("mis_sh", st_misalign, 1);
    applyStimulus(1'b1, 32'h3000, 32'h3333_3333, 2'b11, 1'b1);
    step();
    checkOutput("mis_ill", st_misalign, 1);
    checkOutput("mis_empty", empty, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    step();
    checkOutput("mis_clear", st_misalign, 0);
    checkOutput("mis_no_req", mem_req, 0);
    drainAll();

    // Load hazard against a pending word store.
    $display("[TB] load hazard");
    applyStimulus(1'b1, 32'h4004, 32'hCAFE_F00D, 2'b00, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    ld_valid = 1'b1;
    ld_addr  = 32'h4006;
    #1 checkOutput("hz_hit", ld_hazard, 1);
    ld_addr = 32'h4008;
    #1 checkOutput("hz_miss", ld_hazard, 0);
    step();
    mem_ready = 1'b1;
    step();
    ld_addr = 32'h4006;
    #1 checkOutput("hz_after_write", ld_hazard, 0);
    drainAll();

    // Push and pop together on a full buffer, then reset mid-transfer.
    $display("[TB] full push+pop and async reset");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h6000 + 32'(4 * i), 32'h600 + 32'(i), 2'b00, 1'b0);
      step();
    end
    applyStimulus(1'b1, 32'h6010, 32'h604, 2'b00, 1'b1);
    #1 checkOutput("pp_stall", st_stall, 0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #1 checkOutput("pp_still_full", st_stall, 1);
    checkOutput("pp_req", mem_req, 1);
    #1 rst_n = 1'b0;
    #1 checkOutput("async_req", mem_req, 0);
    checkOutput("async_empty", empty, 1);
    #3 rst_n = 1'b1;
    step();

    // Randomized traffic on a narrow address window so hazards occur.
    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      rdyPct = ((c / 150) % 2 == 1) ? 20 : 85;
      applyStimulus(($urandom_range(0, 99) < 55), 32'h5000 + 32'($urandom_range(0, 31)), $urandom,
                    (($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2))),
                    ($urandom_range(0, 99) < rdyPct));
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 32'h5000 + 32'($urandom_range(0, 31));
      step();
    end
    drainAll();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_ctrl.md
Name: store_ctrl

Overview:
- Store-path sequencer between the single-cycle core's execute stage and the data memory.
- Accepts store requests (sw/sh/sb), aligns the data to its byte lanes and builds write strobes.
- Holds requests in a small in-order FIFO and drains them to memory over a valid/ready handshake.
- Raises a stall when full, and flags loads that hit a pending store so the core can wait.

Parameters:
DEPTH, 4, store buffer entries (power of two, 2..16)
AW, 32, address width
DW, 32, data width (fixed 32; byte strobes are DW/8 = 4)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
st_valid  in  1  store request this cycle
st_addr  in  AW  byte address of store
st_data  in  32  rs2 data, low-justified
st_size  in  2  00 sw, 01 sh, 10 sb, 11 illegal
st_stall  out  1  buffer full, core must hold the store
st_misalign  out  1  one-cycle pulse: accepted request was misaligned or illegal and was dropped
ld_addr  in  AW  current load address
ld_valid  in  1  load in progress
ld_hazard  out  1  a pending store overlaps ld_addr's word (combinational)
mem_req  out  1  write request to data memory
mem_addr  out  AW  word-aligned address (low 2 bits zero)
mem_wdata  out  32  lane-aligned data
mem_wstrb  out  4  byte enables
mem_ready  in  1  memory accepts the write this cycle
empty  out  1  no pending stores (fence/drain indication)

Behaviour:
- Reset is asynchronous, active-low. While reset is asserted: FIFO pointers and count = 0, mem_req = 0, mem_addr/mem_wdata/mem_wstrb = 0, st_misalign = 0, empty = 1, st_stall = 0.
- Accept condition:
  - A request is taken when st_valid && !st_stall.
  - st_stall = (count == DEPTH) && !(mem_req && mem_ready). A pop in the same cycle frees a slot.
- Alignment check at accept:
  - sw requires addr[1:0] == 0.
  - sh requires addr[0] == 0.
  - sb is always aligned.
  - size 11 is illegal.
  - A failing request is not enqueued; st_misalign pulses high in the following cycle.
- Lane formatting at enqueue, with off = addr[1:0]:
  - sw: wdata = data, strb = 1111.
  - sh: wdata = {2{data[15:0]}}, strb = 0011 << off.
  - sb: wdata = {4{data[7:0]}}, strb = 0001 << off.
  - Entry address = {addr[AW-1:2], 2'b00}.
- Drain FSM, states IDLE and REQ:
  - IDLE: if count > 0, load the head entry into the mem_* registers, assert mem_req, go to REQ. This gives 1 cycle of latency from enqueue into an empty FIFO to mem_req.
  - REQ: hold mem_req/mem_addr/mem_wdata/mem_wstrb stable until mem_ready.
  - On mem_ready: pop the head. If the FIFO still holds entries after the pop, load the next head and stay in REQ (back-to-back, one write per cycle with mem_ready tied high). Otherwise deassert mem_req and go to IDLE.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- ld_hazard:
  - Asserted when ld_valid and any occupied entry (including the in-flight head) has a word address equal to ld_addr[AW-1:2]. Strobes are ignored; the check is conservative.
  - A store enqueued in the same cycle is not checked; the core already forwards the same-cycle store.
- empty = (count == 0) && !mem_req.
- Reset mid-transfer abandons the in-flight write; mem_req drops immediately.

Decomposition:
- Package store_pkg:
  - enum st_size_e {SZ_W = 2'b00, SZ_H = 2'b01, SZ_B = 2'b10, SZ_ILL = 2'b11}, shared with the control unit's store-size encoding.
  - struct st_entry_t {addr, wdata, strb}.
  - Drain FSM state enum.
- One sub-module, st_lane_fmt: combinational alignment check plus lane/strobe generation. store_ctrl holds the FIFO, FSM and hazard compare.

Test Plan:
- Reset, then sb addr 0x1003 data 0xAB with mem_ready=1 -> next cycle mem_req=1, mem_addr=0x1000, mem_wdata=0xABABABAB, mem_wstrb=1000; empty returns to 1 the cycle after.
- sh addr 0x2002 data 0x1234_BEEF with mem_ready=0 for 3 cycles -> mem_wdata=0xBEEFBEEF, wstrb=1100 held stable all 3 cycles; popped on the ready cycle.
- mem_ready=0, 5 sw to 0x0,0x4,..,0x10 -> st_stall=1 on the 5th; release ready -> 4 writes in order, then the 5th accepted and written; count never exceeds 4.
- sw addr 0x3001, sh addr 0x3003, size 11 -> st_misalign pulses 3 times; no mem_req issued; empty stays 1.
- Pending sw to 0x4004 with mem_ready=0; ld_valid with ld_addr 0x4006 -> ld_hazard=1; ld_addr 0x4008 -> ld_hazard=0; after the write completes, 0x4006 -> ld_hazard=0.
- Full FIFO with mem_ready=1 and st_valid in the same cycle -> st_stall=0, push and pop both occur, count stays 4; assert rst_n low mid-REQ -> mem_req=0 asynchronously and empty=1.
